// File: rtl/bp_update_sched_pkg.sv
// Shared types and constants for the branch-predictor update scheduler.
// Holds the queued-update record layout and the scheduler state encoding.
package bp_update_sched_pkg;

  localparam int unsigned ALIAS_W      = 6;
  localparam int unsigned INIT_ENTRIES = 1 << ALIAS_W;
  localparam int unsigned ADDR_W       = 32;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } sched_state_e;

  // Field order fixes the packed layout; offsets below are relative to bit 0 (eip).
  typedef struct packed {
    logic               br_result;
    logic [ALIAS_W-1:0] br_alias;
    logic [ADDR_W-1:0]  br_eip;
    logic [ADDR_W-1:0]  fip_e;
    logic [ADDR_W-1:0]  fip_o;
    logic [ADDR_W-1:0]  eip;
  } upd_entry_t;

  localparam int unsigned ENTRY_W    = $bits(upd_entry_t);
  localparam int unsigned OFF_EIP    = 0;
  localparam int unsigned OFF_FIP_O  = OFF_EIP + ADDR_W;
  localparam int unsigned OFF_FIP_E  = OFF_FIP_O + ADDR_W;
  localparam int unsigned OFF_BR_EIP = OFF_FIP_E + ADDR_W;
  localparam int unsigned OFF_ALIAS  = OFF_BR_EIP + ADDR_W;
  localparam int unsigned OFF_RESULT = OFF_ALIAS + ALIAS_W;

  // Clearing write for one PHT/BTB slot during the post-reset sweep.
  function automatic upd_entry_t sweep_entry(logic [ALIAS_W-1:0] idx);
    upd_entry_t e;
    e          = '0;
    e.br_alias = idx;
    return e;
  endfunction

endpackage

// File: rtl/bp_update_sched_if.sv
// WB-to-scheduler and scheduler-to-predictor signal bundle.
// master = WB / fetch side, slave = the scheduler.
interface bp_update_sched_if;
  import bp_update_sched_pkg::*;

  logic               wb_valid;
  logic               wb_BR_result;
  logic [ALIAS_W-1:0] wb_BR_alias;
  logic [ADDR_W-1:0]  wb_br_eip;
  logic [ADDR_W-1:0]  wb_FIP_E;
  logic [ADDR_W-1:0]  wb_FIP_O;
  logic [ADDR_W-1:0]  wb_EIP;
  logic               upd_hold;
  logic               wb_ready;

  logic               upd_LD;
  logic               upd_is_BR;
  logic               upd_BR_result;
  logic [ALIAS_W-1:0] upd_BR_alias;
  logic [ADDR_W-1:0]  upd_br_eip;
  logic [ADDR_W-1:0]  upd_FIP_E;
  logic [ADDR_W-1:0]  upd_FIP_O;
  logic [ADDR_W-1:0]  upd_EIP;
  logic               init_busy;

  modport master (
    output wb_valid, wb_BR_result, wb_BR_alias, wb_br_eip, wb_FIP_E, wb_FIP_O, wb_EIP,
    output upd_hold,
    input  wb_ready,
    input  upd_LD, upd_is_BR, upd_BR_result, upd_BR_alias, upd_br_eip, upd_FIP_E, upd_FIP_O,
    input  upd_EIP, init_busy
  );

  modport slave (
    input  wb_valid, wb_BR_result, wb_BR_alias, wb_br_eip, wb_FIP_E, wb_FIP_O, wb_EIP,
    input  upd_hold,
    output wb_ready,
    output upd_LD, upd_is_BR, upd_BR_result, upd_BR_alias, upd_br_eip, upd_FIP_E, upd_FIP_O,
    output upd_EIP, init_busy
  );

endinterface

// File: rtl/bp_upd_fifo.sv
// Small register-file FIFO for resolved-branch updates.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bp_upd_fifo
  import bp_update_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[IdxW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bp_update_sched.sv
// Owns the predictor/BTB write port: clears every entry after reset, then drains
// queued WB branch resolutions one per cycle in retire order.
module bp_update_sched
  import bp_update_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  bp_update_sched_if.slave bus
);

  sched_state_e       state_q;
  logic [ALIAS_W-1:0] idx_q;
  logic               upd_ld_q;
  logic               upd_is_br_q;
  logic               init_busy_q;
  upd_entry_t         upd_q;

  upd_entry_t         wb_entry;
  upd_entry_t         head;
  logic [ENTRY_W-1:0] head_raw;
  logic               fifo_full, fifo_empty;
  logic               running, wb_ready, push, pop;

  assign running  = (state_q == StRun);
  assign wb_ready = ~fifo_full & running;
  assign push     = bus.wb_valid & wb_ready;
  assign pop      = running & ~fifo_empty & ~bus.upd_hold;

  assign wb_entry = '{
    br_result: bus.wb_BR_result,
    br_alias:  bus.wb_BR_alias,
    br_eip:    bus.wb_br_eip,
    fip_e:     bus.wb_FIP_E,
    fip_o:     bus.wb_FIP_O,
    eip:       bus.wb_EIP
  };
  assign head = upd_entry_t'(head_raw);

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wb_entry),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInit;
      idx_q       <= '0;
      upd_ld_q    <= 1'b0;
      upd_is_br_q <= 1'b0;
      init_busy_q <= 1'b1;
      upd_q       <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          // Sweep ignores upd_hold: nothing reads the predictor while init_busy is high.
          upd_ld_q    <= 1'b1;
          upd_is_br_q <= 1'b1;
          upd_q       <= sweep_entry(idx_q);
          idx_q       <= idx_q + ALIAS_W'(1);
          if (idx_q == ALIAS_W'(INIT_ENTRIES - 1)) begin
            state_q     <= StRun;
            init_busy_q <= 1'b0;
          end
        end
        StRun: begin
          if (pop) begin
            upd_ld_q    <= 1'b1;
            upd_is_br_q <= 1'b1;
            upd_q       <= head;
          end else begin
            upd_ld_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StInit;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.wb_ready      = wb_ready;
  assign bus.upd_LD        = upd_ld_q;
  assign bus.upd_is_BR     = upd_is_br_q;
  assign bus.upd_BR_result = upd_q.br_result;
  assign bus.upd_BR_alias  = upd_q.br_alias;
  assign bus.upd_br_eip    = upd_q.br_eip;
  assign bus.upd_FIP_E     = upd_q.fip_e;
  assign bus.upd_FIP_O     = upd_q.fip_o;
  assign bus.upd_EIP       = upd_q.eip;
  assign bus.init_busy     = init_busy_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: queue-based reference model stepped once per clock,
// directed scenarios plus a randomized push/hold run.
module tb_bp_update_sched;
  import bp_update_sched_pkg::*;

  localparam int unsigned DEPTH = 4;
  typedef logic [ENTRY_W+3:0] obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bp_update_sched_if bus();

  bp_update_sched #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a sweep counter before going live, then a bounded queue.
  bit         m_running;
  int         m_idx;
  upd_entry_t m_q[$];
  bit         m_ld, m_is_br, m_busy;
  upd_entry_t m_last;

  function automatic bit m_ready();
    return m_running && (m_q.size() < DEPTH);
  endfunction

  function automatic upd_entry_t out_entry();
    upd_entry_t e;
    e = '{br_result: bus.upd_BR_result, br_alias: bus.upd_BR_alias, br_eip: bus.upd_br_eip,
          fip_e: bus.upd_FIP_E, fip_o: bus.upd_FIP_O, eip: bus.upd_EIP};
    return e;
  endfunction

  function automatic obs_t observed();
    return {bus.upd_LD, bus.upd_is_BR, out_entry(), bus.wb_ready, bus.init_busy};
  endfunction

  function automatic obs_t expected();
    return {m_ld, m_is_br, m_last, m_ready(), m_busy};
  endfunction

  function automatic upd_entry_t rand_entry();
    upd_entry_t e;
    e.br_result = 1'($urandom_range(0, 1));
    e.br_alias  = ALIAS_W'($urandom);
    e.br_eip    = $urandom;
    e.fip_e     = $urandom;
    e.fip_o     = $urandom;
    e.eip       = $urandom;
    return e;
  endfunction

  task automatic drive(input bit v, input upd_entry_t e);
    bus.wb_valid     = v;
    bus.wb_BR_result = e.br_result;
    bus.wb_BR_alias  = e.br_alias;
    bus.wb_br_eip    = e.br_eip;
    bus.wb_FIP_E     = e.fip_e;
    bus.wb_FIP_O     = e.fip_o;
    bus.wb_EIP       = e.eip;
  endtask

  // One clock: model consumes the inputs present at the edge, outputs sampled 1 time unit later.
  task automatic tick();
    bit         r, v, h, push;
    upd_entry_t e;
    @(posedge clk);
    r = reset;
    v = bus.wb_valid;
    h = bus.upd_hold;
    e = '{br_result: bus.wb_BR_result, br_alias: bus.wb_BR_alias, br_eip: bus.wb_br_eip,
          fip_e: bus.wb_FIP_E, fip_o: bus.wb_FIP_O, eip: bus.wb_EIP};
    if (r) begin
      m_running = 0; m_idx = 0; m_q.delete();
      m_ld = 0; m_is_br = 0; m_last = '0; m_busy = 1;
    end else if (!m_running) begin
      m_ld = 1; m_is_br = 1;
      m_last = '0;
      m_last.br_alias = ALIAS_W'(m_idx);
      if (m_idx == INIT_ENTRIES - 1) begin
        m_running = 1;
        m_busy    = 0;
      end
      m_idx++;
    end else begin
      push = v && (m_q.size() < DEPTH);
      if (m_q.size() > 0 && !h) begin
        m_ld = 1; m_is_br = 1;
        m_last = m_q.pop_front();
      end else begin
        m_ld = 0;
      end
      if (push) m_q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.upd_hold = 1'b0;
    drive(1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if ({bus.upd_LD, bus.init_busy, bus.wb_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 010", {bus.upd_LD, bus.init_busy, bus.wb_ready});
    end
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", observed(), expected());
    end
  endtask

  // Must run immediately after test_reset (sweep starts on the first non-reset edge).
  task automatic test_init_sweep();
    int ld_cnt = 0;
    int busy_cnt = 0;
    for (int i = 0; i < int'(INIT_ENTRIES); i++) begin
      tick();
      if (bus.upd_LD === 1'b1) ld_cnt++;
      if (bus.init_busy === 1'b1) busy_cnt++;
      n_checks++;
      if ({bus.upd_LD, bus.upd_is_BR, bus.upd_BR_alias, bus.upd_BR_result, bus.upd_br_eip}
          !== {1'b1, 1'b1, ALIAS_W'(i), 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL sweep_idx%0d: got alias %0d ld %b res %b", i, bus.upd_BR_alias,
                 bus.upd_LD, bus.upd_BR_result);
      end
    end
    // The reset-state cycle also had init_busy high, so 63 here makes 64 in total.
    n_checks++;
    if (ld_cnt != 64 || busy_cnt != 63) begin
      n_fail++;
      $display("FAIL sweep_counts: got ld %0d busy %0d want 64 63", ld_cnt, busy_cnt);
    end
    tick();
    n_checks++;
    if ({bus.upd_LD, bus.init_busy, bus.wb_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL sweep_done: got %b want 001", {bus.upd_LD, bus.init_busy, bus.wb_ready});
    end
  endtask

  task automatic test_single();
    upd_entry_t e;
    e = rand_entry();
    e.br_result = 1'b1; e.br_alias = 6'h2A; e.br_eip = 32'h1000; e.eip = 32'h2000;
    drive(1'b1, e);
    tick();
    drive(1'b0, '0);
    n_checks++;
    if (observed() !== expected() || bus.upd_LD !== 1'b0) begin
      n_fail++;
      $display("FAIL single_enqueue: got %h want %h", observed(), expected());
    end
    tick();
    n_checks++;
    if ({bus.upd_LD, bus.upd_BR_result, bus.upd_BR_alias, bus.upd_br_eip, bus.upd_EIP}
        !== {1'b1, 1'b1, 6'h2A, 32'h1000, 32'h2000}) begin
      n_fail++;
      $display("FAIL single_issue: got ld %b alias %h br_eip %h eip %h", bus.upd_LD,
               bus.upd_BR_alias, bus.upd_br_eip, bus.upd_EIP);
    end
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL single_fields: got %h want %h", observed(), expected());
    end
    tick();
    n_checks++;
    if (bus.upd_LD !== 1'b0 || out_entry() !== e) begin
      n_fail++;
      $display("FAIL single_hold_data: got ld %b entry %h want 0 %h", bus.upd_LD, out_entry(), e);
    end
  endtask

  task automatic test_hold_fill();
    upd_entry_t pushed[4];
    bus.upd_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pushed[i] = rand_entry();
      drive(1'b1, pushed[i]);
      tick();
    end
    drive(1'b0, '0);
    n_checks++;
    if (bus.wb_ready !== 1'b0 || bus.upd_LD !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got ready %b ld %b want 0 0", bus.wb_ready, bus.upd_LD);
    end
    bus.upd_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus.upd_LD, out_entry()} !== {1'b1, pushed[i]}) begin
        n_fail++;
        $display("FAIL fill_drain%0d: got %b %h want 1 %h", i, bus.upd_LD, out_entry(), pushed[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (bus.wb_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_ready_back: got %b want 1", bus.wb_ready);
        end
      end
    end
    tick();
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL fill_idle: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_back_to_back();
    upd_entry_t pushed[$];
    upd_entry_t issued[$];
    upd_entry_t e;
    bus.upd_hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        e = rand_entry();
        pushed.push_back(e);
        drive(1'b1, e);
      end else begin
        drive(1'b0, '0);
      end
      tick();
      if (bus.upd_LD === 1'b1) issued.push_back(out_entry());
      n_checks++;
      if (bus.upd_LD !== ((i >= 1) && (i <= 10))) begin
        n_fail++;
        $display("FAIL b2b_ld%0d: got %b", i, bus.upd_LD);
      end
    end
    n_checks++;
    if (issued.size() != pushed.size() || issued != pushed) begin
      n_fail++;
      $display("FAIL b2b_order: got %0d issued want %0d in push order", issued.size(),
               pushed.size());
    end
  endtask

  task automatic test_reset_mid();
    bus.upd_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_entry());
      tick();
    end
    drive(1'b0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i <= 30; i++) tick();
    n_checks++;
    if (bus.upd_BR_alias !== 6'd30 || bus.upd_LD !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_sweep30: got alias %0d ld %b", bus.upd_BR_alias, bus.upd_LD);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({bus.upd_LD, bus.upd_BR_alias, bus.init_busy} !== {1'b1, 6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_restart: got ld %b alias %0d busy %b", bus.upd_LD, bus.upd_BR_alias,
               bus.init_busy);
    end
    for (int i = 1; i < int'(INIT_ENTRIES); i++) tick();
    bus.upd_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.upd_LD !== 1'b0 || observed() !== expected()) begin
        n_fail++;
        $display("FAIL mid_discard%0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_wb_during_init();
    upd_entry_t junk;
    junk = '{br_result: 1'b1, br_alias: 6'h15, br_eip: 32'hDEADBEEF, fip_e: 32'h11,
             fip_o: 32'h22, eip: 32'hCAFEF00D};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, junk);
    for (int i = 0; i < int'(INIT_ENTRIES); i++) begin
      n_checks++;
      if (bus.wb_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL init_ready%0d: got %b want 0", i, bus.wb_ready);
      end
      tick();
    end
    drive(1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.upd_LD !== 1'b0 || bus.upd_br_eip === 32'hDEADBEEF ||
          observed() !== expected()) begin
        n_fail++;
        $display("FAIL init_drop%0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.upd_hold = ($urandom_range(0, 99) < 30);
      drive(($urandom_range(0, 99) < 65), rand_entry());
      tick();
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL random%0d: got %h want %h", i, observed(), expected());
      end
    end
    drive(1'b0, '0);
    bus.upd_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_single();
    test_hold_fill();
    test_back_to_back();
    test_reset_mid();
    test_wb_during_init();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
